// File: rtl/i2c_slave_target.sv
// i2c_slave_target: byte-oriented I2C target with a 7-bit address.
// The system clock oversamples the bus. START and STOP are recognised in
// every state and take priority over data edges.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter
// on SCL and SDA after the synchronisers (+2 clk latency).
module i2c_slave_target #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       addr_match,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   logic   scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
   logic   scl_c, sda_c;
   logic   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic   scl_rise, scl_fall, start_det, stop_det;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       phase_q, phase_d;
   logic       ack_q, ack_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       addr_match_q, addr_match_d;
   logic       busy_q, busy_d;

   // Two-flop synchronisers; idle bus level is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
      end else begin
         scl_s1_q <= i2c_scl;
         scl_s2_q <= scl_s1_q;
         sda_s1_q <= i2c_sda;
         sda_s2_q <= sda_s1_q;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic scl_h0_q, scl_h1_q, scl_f_q, sda_h0_q, sda_h1_q, sda_f_q;

   // Majority of three consecutive samples suppresses single-clk pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_h0_q <= 1'b1;
         scl_h1_q <= 1'b1;
         scl_f_q  <= 1'b1;
         sda_h0_q <= 1'b1;
         sda_h1_q <= 1'b1;
         sda_f_q  <= 1'b1;
      end else begin
         scl_h0_q <= scl_s2_q;
         scl_h1_q <= scl_h0_q;
         scl_f_q  <= (scl_s2_q & scl_h0_q) | (scl_s2_q & scl_h1_q) | (scl_h0_q & scl_h1_q);
         sda_h0_q <= sda_s2_q;
         sda_h1_q <= sda_h0_q;
         sda_f_q  <= (sda_s2_q & sda_h0_q) | (sda_s2_q & sda_h1_q) | (sda_h0_q & sda_h1_q);
      end
   end

   assign scl_c = scl_f_q;
   assign sda_c = sda_f_q;
`else
   assign scl_c = scl_s2_q;
   assign sda_c = sda_s2_q;
`endif

   assign scl_rise  = scl_c & ~scl_prev_q;
   assign scl_fall  = ~scl_c & scl_prev_q;
   assign start_det = scl_c & scl_prev_q & ~sda_c & sda_prev_q;
   assign stop_det  = scl_c & scl_prev_q & sda_c & ~sda_prev_q;

   // Next-state logic for the protocol engine and its registered outputs.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      phase_d      = phase_q;
      ack_d        = ack_q;
      rw_d         = rw_q;
      sda_oe_d     = sda_oe_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      tx_req_d     = 1'b0;
      addr_match_d = addr_match_q;
      busy_d       = busy_q;
      scl_prev_d   = scl_c;
      sda_prev_d   = sda_c;

      // tx_data is captured in the cycle tx_req is high, and its MSB is
      // presented on the bus at the same time.
      if (tx_req_q) begin
         shift_d   = tx_data;
         sda_oe_d  = ~tx_data[7];
         bit_cnt_d = '0;
      end

      if (stop_det) begin
         state_d      = IDLE;
         sda_oe_d     = 1'b0;
         addr_match_d = 1'b0;
         busy_d       = 1'b0;
      end else if (start_det) begin
         state_d      = ADDR;
         bit_cnt_d    = '0;
         phase_d      = 1'b0;
         sda_oe_d     = 1'b0;
         addr_match_d = 1'b0;
         busy_d       = 1'b1;
      end else begin
         unique case (state_q)
            ADDR: if (scl_rise) begin
               shift_d   = {shift_q[6:0], sda_c};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  phase_d = 1'b0;
                  rw_d    = sda_c;
                  state_d = (shift_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
               end
            end
            ADDR_ACK, WR_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 1'b1;
                  if (state_q == ADDR_ACK) addr_match_d = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  phase_d   = 1'b0;
                  bit_cnt_d = '0;
                  if (state_q == ADDR_ACK && rw_q) begin
                     tx_req_d = 1'b1;
                     state_d  = RD_DATA;
                  end else begin
                     state_d = WR_DATA;
                  end
               end
            end
            WR_DATA: if (scl_rise) begin
               shift_d   = {shift_q[6:0], sda_c};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {shift_q[6:0], sda_c};
                  rx_valid_d = 1'b1;
                  phase_d    = 1'b0;
                  state_d    = WR_ACK;
               end
            end
            RD_DATA: if (scl_fall) begin
               if (bit_cnt_q == 3'd7) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  phase_d   = 1'b0;
                  state_d   = RD_ACK;
               end else begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  sda_oe_d  = ~shift_q[6];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  ack_d   = ~sda_c;
                  phase_d = 1'b1;
               end else if (scl_fall && phase_q) begin
                  phase_d = 1'b0;
                  if (ack_q) begin
                     tx_req_d = 1'b1;
                     state_d  = RD_DATA;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and output registers; reset releases SDA immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         phase_q      <= 1'b0;
         ack_q        <= 1'b0;
         rw_q         <= 1'b0;
         sda_oe_q     <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         tx_req_q     <= 1'b0;
         addr_match_q <= 1'b0;
         busy_q       <= 1'b0;
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         phase_q      <= phase_d;
         ack_q        <= ack_d;
         rw_q         <= rw_d;
         sda_oe_q     <= sda_oe_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         tx_req_q     <= tx_req_d;
         addr_match_q <= addr_match_d;
         busy_q       <= busy_d;
         scl_prev_q   <= scl_prev_d;
         sda_prev_q   <= sda_prev_d;
      end
   end

   assign i2c_sda    = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign tx_req     = tx_req_q;
   assign addr_match = addr_match_q;
   assign busy       = busy_q;

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

Byte-oriented I2C target (slave) that sits directly downstream of the team's I2C master on the shared SCL/SDA bus. It oversamples the bus with its own system clock, detects START/STOP, matches a 7-bit address and ACKs it, then either delivers received write bytes to local logic or serialises bytes supplied by local logic for a master read. It is the bus-side responder used as the DUT partner in bench and system integration.

## Interface
- SLAVE_ADDR, default 7'h50: 7-bit address this target answers to.
- clk  in  1  system clock; must run at least 8× the SCL frequency.
- reset  in  1  asynchronous, active-high reset.
- i2c_scl  in  1  bus clock from the master.
- i2c_sda  inout  1  bus data; open-drain: driven 0 or released to 'z, never driven 1.
- tx_data  in  8  byte returned to the master on a read; sampled when tx_req pulses.
- rx_data  out  8  last byte received on a write; holds until the next byte completes.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- tx_req  out  1  one-clk pulse; tx_data latched into the shift register in that same cycle.
- addr_match  out  1  high from the address ACK until STOP or repeated START.
- busy  out  1  high from START detection until STOP detection.

## Operation
- Input conditioning: i2c_scl and i2c_sda each pass a 2-flop synchroniser; edges taken from synchronised values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Either is recognised in any state.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE -> ADDR on START; bit counter cleared; busy set.
- ADDR: shift 8 bits MSB first on SCL rising edges (7 address + R/W). After 8th bit: match -> ADDR_ACK, mismatch -> IGNORE.
- ADDR_ACK: pull SDA low from next SCL fall to the following SCL fall; addr_match set. Then R/W=0 -> WR_DATA, R/W=1 -> pulse tx_req, load tx_data, -> RD_DATA.
- WR_DATA: shift 8 bits; after 8th rising edge update rx_data, pulse rx_valid, -> WR_ACK. WR_ACK drives ACK as in ADDR_ACK, then -> WR_DATA.
- RD_DATA: present bit 7 immediately, next bits on each SCL fall, 0 bits pull low, 1 bits release. After 8th bit release SDA -> RD_ACK.
- RD_ACK: sample SDA on SCL rise. Low (master ACK) -> pulse tx_req, reload, -> RD_DATA. High (NACK) -> IGNORE.
- IGNORE: SDA released; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP in any state -> IDLE, SDA released, addr_match and busy cleared. Repeated START in any state -> ADDR, addr_match cleared, partial byte discarded (no rx_valid).
- Shift register and counter 3-bit wrap at 8; no rx FIFO: local logic must consume rx_data within one byte time.

## Timing
- Reset values: rx_data 8'h00, rx_valid 0, tx_req 0, addr_match 0, busy 0, SDA released, state IDLE; reset mid-transfer releases SDA asynchronously.
- Detection latency: 2 clk from bus pin to internal edge (4 clk with filter enabled).
- SDA drive/release changes within 1 clk of detected SCL fall; never changes while synchronised SCL is high, except STOP/START response.
- rx_valid asserts 1 clk after detected 8th SCL rise of a write byte.
- tx_req asserts 1 clk after detected SCL fall ending the ACK bit; tx_data must be stable that cycle.
- START and STOP detected in the same clk as a data edge take priority over it.

## Configuration
- I2C_SLAVE_GLITCH_FILTER_EN defined: after synchronisers, SCL and SDA each pass a 3-sample majority filter; pulses of 1 clk are suppressed; latency +2 clk.
- Not defined: synchronised signals used directly; single-clk glitches are treated as edges.

## Test plan
- Write: START, 0xA0 (addr 0x50, W), 0xA5, STOP -> SDA low in both ACK slots, rx_data=0xA5, one rx_valid pulse, busy low after STOP.
- Mismatch: START, 0xA2 (addr 0x51), 0x11, STOP -> SDA never driven, no rx_valid, addr_match stays 0.
- Read: tx_data=0x3C, START, 0xA1, master ACKs first byte, NACKs second with tx_data=0xC3 -> SDA bits 00111100 then 11000011, exactly two tx_req pulses, SDA released after NACK.
- Repeated START: write 0xA0, 4 bits of data, START, 0xA1 -> no rx_valid, address re-ACKed, tx_req pulses.
- Reset mid-byte: assert reset while SDA driven in ACK slot -> SDA released same cycle, all outputs at reset values, next START accepted normally.
- Filter (macro defined): 1-clk low glitch on SDA while SCL high in IDLE -> busy stays 0; without macro busy rises.
